// File: rtl/anc_frame_sched.sv
// Per-sample frame scheduler for the ANC adaptive FIR: pairs ref/err mic samples,
// forms the saturated LMS weight step, launches one FIR run and forwards the result.
module anc_frame_sched #(
  parameter int DW      = 32,
  parameter int MUW     = 16,
  parameter int FRAC    = 15,
  parameter int TIMEOUT = 256,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        ref_sample,
  input  logic                 ref_valid,
  input  logic [DW-1:0]        err_sample,
  input  logic                 err_valid,
  input  logic                 adapt_en,
  input  logic [MUW-1:0]       mu,
  input  logic                 clr_status,
  output logic [DW-1:0]        fir_feedforward,
  output logic [DW-1:0]        fir_weight_adjust,
  output logic                 fir_go,
  input  logic [DW-1:0]        fir_out_sample,
  input  logic                 fir_done,
  output logic [DW-1:0]        spk_sample,
  output logic                 spk_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic [CNTW-1:0]      frame_cnt
);
  localparam int PW = DW + MUW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MUL, GO, WAIT} state_t;

  state_t          state;
  logic [DW-1:0]   ref_q, err_q;
  logic            have_ref, have_err;
  logic [TW-1:0]   timer;

  logic signed [PW-1:0] prod, shf;
  logic [PW-DW:0]       upper;
  logic [DW-1:0]        step_sat;
  logic                 to_evt, ovr_evt;

  // Full-width signed product, floor shift, then clamp to DW signed.
  always_comb begin
    prod     = $signed(err_q) * $signed({1'b0, mu});
    shf      = prod >>> FRAC;
    upper    = shf[PW-1:DW-1];
    step_sat = shf[DW-1:0];
    if (!((&upper) || !(|upper)))
      step_sat = shf[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  assign busy    = (state != IDLE);
  assign ovr_evt = busy && (ref_valid || err_valid);
  assign to_evt  = (state == WAIT) && !fir_done && (timer == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      ref_q             <= '0;
      err_q             <= '0;
      have_ref          <= 1'b0;
      have_err          <= 1'b0;
      timer             <= '0;
      fir_feedforward   <= '0;
      fir_weight_adjust <= '0;
      fir_go            <= 1'b0;
      spk_sample        <= '0;
      spk_valid         <= 1'b0;
      overrun           <= 1'b0;
      timeout_err       <= 1'b0;
      frame_cnt         <= '0;
    end else begin
      fir_go    <= 1'b0;
      spk_valid <= 1'b0;
      // set events take priority over a same-cycle clear
      if (ovr_evt)         overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;
      if (to_evt)          timeout_err <= 1'b1;
      else if (clr_status) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (ref_valid) begin ref_q <= ref_sample; have_ref <= 1'b1; end
          if (err_valid) begin err_q <= err_sample; have_err <= 1'b1; end
          if ((have_ref || ref_valid) && (have_err || err_valid)) state <= MUL;
        end
        MUL: begin
          fir_feedforward   <= ref_q;
          fir_weight_adjust <= adapt_en ? step_sat : '0;
          have_ref          <= 1'b0;
          have_err          <= 1'b0;
          fir_go            <= 1'b1;
          state             <= GO;
        end
        GO: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (fir_done) begin
            spk_sample <= fir_out_sample;
            spk_valid  <= 1'b1;
            frame_cnt  <= frame_cnt + CNTW'(1);
            state      <= IDLE;
          end else if (timer == T_LAST) begin
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
